// File: rtl/bubble_shot_resolver.sv
// bubble_shot_resolver: resolves one shot against a snapshot of the 8x4 bubble
// grid. Scans the fired column bottom-up for the first occupied cell, and on a
// colour match grows the same-colour horizontal run around it one step per
// cycle. Reports the popped run as a one-cycle registered result and keeps a
// saturating score of count^2 per pop.
//
// Handshake: a shot transfers on any rising edge where shot_valid && shot_ready.
// shot_ready is high only while idle with en=1, so the shot inputs need to be
// stable only in that cycle. Every accepted shot yields exactly one res_valid
// pulse. res_* hold their values afterwards until the next result or reset.
module bubble_shot_resolver #(
  parameter logic [4:0] DARK    = 5'd31,
  parameter int         SCORE_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [39:0]        row1,
  input  logic [39:0]        row2,
  input  logic [39:0]        row3,
  input  logic [39:0]        row4,
  input  logic               shot_valid,
  input  logic [2:0]         shot_col,
  input  logic [4:0]         shot_color,
  output logic               shot_ready,
  output logic               res_valid,
  output logic [1:0]         res_kind,
  output logic [1:0]         res_row,
  output logic [7:0]         res_mask,
  output logic [3:0]         res_count,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SCAN   = 2'd1,
    S_EXPAND = 2'd2,
    S_RESULT = 2'd3
  } state_t;

  localparam logic [1:0] KIND_MISS     = 2'd0;
  localparam logic [1:0] KIND_MISMATCH = 2'd1;
  localparam logic [1:0] KIND_POP      = 2'd2;

  // snap index 0 is row1 (top), index 3 is row4 (bottom)
  state_t             state_q, state_d;
  logic [3:0][39:0]   snap_q, snap_d;
  logic [2:0]         col_q, col_d;
  logic [4:0]         color_q, color_d;
  logic [1:0]         row_q, row_d;
  logic [2:0]         left_q, left_d;
  logic [2:0]         right_q, right_d;
  logic               stop_l_q, stop_l_d;
  logic               stop_r_q, stop_r_d;
  logic               res_valid_q, res_valid_d;
  logic [1:0]         res_kind_q, res_kind_d;
  logic [1:0]         res_row_q, res_row_d;
  logic [7:0]         res_mask_q, res_mask_d;
  logic [3:0]         res_count_q, res_count_d;
  logic [SCORE_W-1:0] score_q, score_d;

  // Result staging, committed to res_* when load_res is set
  logic               load_res;
  logic [1:0]         ld_kind;
  logic [1:0]         ld_row;
  logic [7:0]         ld_mask;
  logic [3:0]         ld_cnt;
  logic [7:0]         ld_sq;
  logic [SCORE_W:0]   score_sum;

  logic [39:0]        hit_row;
  logic [4:0]         cur_cell;
  logic [4:0]         l_cell;
  logic [4:0]         r_cell;
  logic               color_ok;
  logic               can_l;
  logic               can_r;

  function automatic logic [4:0] cell_at(input logic [39:0] r, input logic [2:0] c);
    cell_at = r[5*c +: 5];
  endfunction

  // Only the three real bubble colours can ever match; DARK never does.
  always_comb begin
    color_ok = (color_q >= 5'd16) && (color_q <= 5'd18) && (color_q != DARK);
    hit_row  = snap_q[row_q];
    cur_cell = cell_at(hit_row, col_q);
    l_cell   = cell_at(hit_row, left_q - 3'd1);
    r_cell   = cell_at(hit_row, right_q + 3'd1);
    can_l    = !stop_l_q && (left_q != 3'd0) && color_ok && (l_cell == color_q);
    can_r    = !stop_r_q && (right_q != 3'd7) && color_ok && (r_cell == color_q);
  end

  // Next-state, pointer and result computation
  always_comb begin
    state_d     = state_q;
    snap_d      = snap_q;
    col_d       = col_q;
    color_d     = color_q;
    row_d       = row_q;
    left_d      = left_q;
    right_d     = right_q;
    stop_l_d    = stop_l_q;
    stop_r_d    = stop_r_q;
    res_valid_d = 1'b0;
    res_kind_d  = res_kind_q;
    res_row_d   = res_row_q;
    res_mask_d  = res_mask_q;
    res_count_d = res_count_q;
    score_d     = score_q;
    load_res    = 1'b0;
    ld_kind     = KIND_MISS;
    ld_row      = 2'd0;
    ld_mask     = 8'd0;
    ld_cnt      = 4'd0;

    case (state_q)
      S_IDLE: begin
        if (shot_valid && shot_ready) begin
          snap_d  = {row4, row3, row2, row1};
          col_d   = shot_col;
          color_d = shot_color;
          row_d   = 2'd3;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (cur_cell == DARK) begin
          if (row_q == 2'd0) begin
            load_res = 1'b1;
            ld_kind  = KIND_MISS;
            ld_row   = 2'd0;
            state_d  = S_RESULT;
          end else begin
            row_d = row_q - 2'd1;
          end
        end else if (color_ok && (cur_cell == color_q)) begin
          left_d   = col_q;
          right_d  = col_q;
          stop_l_d = 1'b0;
          stop_r_d = 1'b0;
          state_d  = S_EXPAND;
        end else begin
          load_res = 1'b1;
          ld_kind  = KIND_MISMATCH;
          ld_row   = row_q;
          state_d  = S_RESULT;
        end
      end
      S_EXPAND: begin
        left_d   = can_l ? (left_q - 3'd1) : left_q;
        right_d  = can_r ? (right_q + 3'd1) : right_q;
        stop_l_d = stop_l_q | !can_l;
        stop_r_d = stop_r_q | !can_r;
        if (stop_l_d && stop_r_d) begin
          load_res = 1'b1;
          ld_kind  = KIND_POP;
          ld_row   = row_q;
          for (int i = 0; i < 8; i++) begin
            ld_mask[i] = (3'(i) >= left_d) && (3'(i) <= right_d);
          end
          ld_cnt  = {1'b0, right_d} - {1'b0, left_d} + 4'd1;
          state_d = S_RESULT;
        end
      end
      S_RESULT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Score update lands together with res_valid; saturates instead of wrapping
    ld_sq     = {4'd0, ld_cnt} * {4'd0, ld_cnt};
    score_sum = {1'b0, score_q} + {{(SCORE_W-7){1'b0}}, ld_sq};
    if (load_res) begin
      res_valid_d = 1'b1;
      res_kind_d  = ld_kind;
      res_row_d   = ld_row;
      res_mask_d  = ld_mask;
      res_count_d = ld_cnt;
      score_d     = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
    end
  end

  // State register: synchronous active-low reset, everything holds while en=0
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      snap_q      <= '0;
      col_q       <= 3'd0;
      color_q     <= 5'd0;
      row_q       <= 2'd0;
      left_q      <= 3'd0;
      right_q     <= 3'd0;
      stop_l_q    <= 1'b0;
      stop_r_q    <= 1'b0;
      res_valid_q <= 1'b0;
      res_kind_q  <= 2'd0;
      res_row_q   <= 2'd0;
      res_mask_q  <= 8'd0;
      res_count_q <= 4'd0;
      score_q     <= '0;
    end else if (en) begin
      state_q     <= state_d;
      snap_q      <= snap_d;
      col_q       <= col_d;
      color_q     <= color_d;
      row_q       <= row_d;
      left_q      <= left_d;
      right_q     <= right_d;
      stop_l_q    <= stop_l_d;
      stop_r_q    <= stop_r_d;
      res_valid_q <= res_valid_d;
      res_kind_q  <= res_kind_d;
      res_row_q   <= res_row_d;
      res_mask_q  <= res_mask_d;
      res_count_q <= res_count_d;
      score_q     <= score_d;
    end
  end

  // Output mapping
  always_comb begin
    shot_ready = (state_q == S_IDLE) && en;
    res_valid  = res_valid_q;
    res_kind   = res_kind_q;
    res_row    = res_row_q;
    res_mask   = res_mask_q;
    res_count  = res_count_q;
    score      = score_q;
    dbg_state  = state_q;
  end

endmodule

// File: doc/bubble_shot_resolver.md
# bubble_shot_resolver

Resolves one player shot against the 8×4 bubble grid.
- Takes a fired column and bullet colour, plus the four current bubble rows from the bubble manager.
- Finds the lowest occupied cell in that column and, on colour match, pops the contiguous same-colour horizontal run containing it.
- Reports the pop mask and accumulates the score.
- Sits directly downstream of the bubble manager and the shooter; its result mask is consumed by the bubble manager's pop/clear logic.

## Interface
Parameters:
- DARK, 5'd31, empty-cell code
- SCORE_W, 16, score register width

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- en  in  1  global enable; when 0, FSM and all registers hold
- row1..row4  in  40 each  bubble rows; row1 top, row4 bottom; column c = bits [5c+4:5c]; codes 16=R, 17=G, 18=B, DARK=empty
- shot_valid  in  1  shot request
- shot_col  in  3  fired column 0..7
- shot_color  in  5  bullet colour
- shot_ready  out  1  high only in IDLE with en=1
- res_valid  out  1  one-cycle result pulse
- res_kind  out  2  0=miss, 1=mismatch, 2=pop
- res_row  out  2  hit row index (0=row1 … 3=row4); 0 for miss
- res_mask  out  8  popped columns in res_row; 0 unless pop
- res_count  out  4  popped cell count 0..8
- score  out  SCORE_W  accumulated score

## Operation
- States: IDLE, SCAN, EXPAND, RESULT.
- **IDLE**
  - shot_ready=1 when en=1.
  - On shot_valid && shot_ready:
    - latch shot_col and shot_color;
    - snapshot row1..row4 (later row changes are ignored for this shot);
    - set row pointer to row4;
    - go to SCAN.
- **SCAN**, one row per cycle from row4 up to row1:
  - Latched column cell == DARK: move up one row. If the cell was in row1, set kind=miss and go to RESULT.
  - Cell occupied and cell == shot_color: set left and right pointers to shot_col, go to EXPAND.
  - Cell occupied and cell != shot_color: set kind=mismatch and go to RESULT. A shot_color outside 16..18 never matches.
- **EXPAND**, each cycle:
  - For each side not yet stopped, test the next cell (left = col-1, right = col+1).
  - If that cell is in range 0..7 and equals shot_color: extend that side.
  - Otherwise: stop that side.
  - Leave EXPAND at the end of the cycle in which both sides are stopped.
  - Cycle count = max(L,R)+1, where L and R are the number of matching cells to each side.
- **RESULT**, one cycle:
  - res_valid=1 and res_* driven.
  - For a pop: res_mask has bits [left..right] set, res_count = right-left+1.
  - score += res_count², saturating at 2^SCORE_W-1.
  - The new score is visible in the same cycle as res_valid.
  - Next state is IDLE.
- DARK never matches. The block never writes the grid; the consumer clears the cells.

## Timing
- Reset (rst=0 at an edge), from any state including mid-shot:
  - state=IDLE, score=0;
  - res_valid=0, res_kind=0, res_row=0, res_mask=0, res_count=0;
  - latched shot state discarded.
  - shot_ready=1 in the first cycle after release, if en=1.
- res_* are registered and hold their last values after the res_valid pulse until the next RESULT or reset.
- Accept at cycle T; first SCAN at T+1. A hit found in row r (row4=1st, row1=4th scanned) is found at T+k, where k = 4-r+1.
  - Miss: RESULT at T+5.
  - Mismatch: RESULT at T+k+1.
  - Pop: RESULT at T+k+max(L,R)+2.
- Throughput: a new shot may be accepted in the cycle immediately after RESULT. Minimum shot-to-shot interval is 3 cycles.
- shot_valid while not IDLE is ignored. Each handshake produces exactly one res_valid.
- en=0 mid-shot: state and pointers freeze, no res_valid. Resumes exactly where it stopped when en returns to 1.

## Test plan
- Reset then idle → all outputs 0, score=0, shot_ready=1.
- Empty grid (all DARK), shot col 5 colour 16 at T → RESULT at T+5: kind=0, mask=0, count=0, score unchanged.
- row1 = col7..0 {R,R,B,B,B,B,G,G}, rows2-4 DARK; shot col 3 colour 18 at T → found T+4, EXPAND T+5..T+7, RESULT T+8: kind=2, row=0, mask=8'b0011_1100, count=4, score=16.
- Same grid, shot col 0 colour 16 → RESULT at T+5: kind=1, mask=0, score unchanged. shot_valid held high during busy → exactly one result.
- row4 all 17; shot col 0 colour 17 repeated 1024 times → each pop gives mask=8'hFF, count=8, +64; score saturates at 65535.
- Reset (rst=0) asserted during EXPAND → next cycle IDLE, score=0, no res_valid. A fresh shot then resolves normally. en=0 for 3 cycles mid-SCAN → RESULT delayed by exactly 3 cycles.
